// File: rtl/rgb_hue_sequencer.sv
// Hue-wheel colour source: one ramp/segment pair drives all three channels, scaled by brightness.
// Step lands one edge after a prescaler tick and the output register loads on the next; a stalled triple freezes everything.
module rgb_hue_sequencer #(
  parameter int R           = 8,
  parameter int STEP_THRESH = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [R-1:0] bright,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [R-1:0] duty_r,
  output logic [R-1:0] duty_g,
  output logic [R-1:0] duty_b,
  output logic [2:0]   seg
);

  localparam int            PW   = (STEP_THRESH > 1) ? $clog2(STEP_THRESH) : 1;
  localparam logic [R-1:0]  MAX  = '1;
  localparam logic [PW-1:0] LAST = PW'(STEP_THRESH - 1);

  logic [R-1:0]  ramp;
  logic [PW-1:0] presc;
  logic          prime;
  logic          step_pend;
  logic          stall;
  logic          run;
  logic          tick;
  logic          load;

  logic [R-1:0]  raw_r, raw_g, raw_b;
  logic [R-1:0]  up, dn;
  logic [R:0]    gain;
  logic [2*R:0]  prod_r, prod_g, prod_b;

  assign stall = out_valid & ~out_ready;
  assign run   = en & ~stall;
  assign tick  = run & (presc == LAST);
  // A pending load waits out a stall so an unaccepted triple is never overwritten.
  assign load  = (prime | step_pend) & ~stall;

  assign up = ramp;
  assign dn = MAX - ramp;

  always_comb begin
    raw_r = '0;
    raw_g = '0;
    raw_b = '0;
    case (seg)
      3'd0: begin raw_r = MAX; raw_g = up;  raw_b = '0;  end
      3'd1: begin raw_r = dn;  raw_g = MAX; raw_b = '0;  end
      3'd2: begin raw_r = '0;  raw_g = MAX; raw_b = up;  end
      3'd3: begin raw_r = '0;  raw_g = dn;  raw_b = MAX; end
      3'd4: begin raw_r = up;  raw_g = '0;  raw_b = MAX; end
      3'd5: begin raw_r = MAX; raw_g = '0;  raw_b = dn;  end
      default: begin raw_r = '0; raw_g = '0; raw_b = '0; end
    endcase
  end

  // bright+1 makes full brightness an exact pass-through after the >>R.
  assign gain   = {1'b0, bright} + (R+1)'(1);
  assign prod_r = (2*R+1)'(raw_r) * (2*R+1)'(gain);
  assign prod_g = (2*R+1)'(raw_g) * (2*R+1)'(gain);
  assign prod_b = (2*R+1)'(raw_b) * (2*R+1)'(gain);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      ramp      <= '0;
      seg       <= 3'd0;
      prime     <= 1'b1;
      step_pend <= 1'b0;
      out_valid <= 1'b0;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
    end else begin
      if (run) begin
        presc <= (presc == LAST) ? '0 : presc + PW'(1);
      end

      if (tick) begin
        if (ramp == MAX) begin
          ramp <= '0;
          seg  <= (seg == 3'd5) ? 3'd0 : seg + 3'd1;
        end else begin
          ramp <= ramp + R'(1);
        end
      end

      if (tick) begin
        step_pend <= 1'b1;
      end else if (load) begin
        step_pend <= 1'b0;
      end

      if (load) begin
        prime     <= 1'b0;
        out_valid <= 1'b1;
        duty_r    <= R'(prod_r >> R);
        duty_g    <= R'(prod_g >> R);
        duty_b    <= R'(prod_b >> R);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Bench for rgb_hue_sequencer (R=8, STEP_THRESH=4): step-indexed hue model plus directed and random scenarios.
module tb_rgb_hue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] bright;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [2:0] seg;

  int n_cmp = 0;
  int n_bad = 0;
  int step  = 0;

  rgb_hue_sequencer #(.R(8), .STEP_THRESH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bright    (bright),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  // Step k of the wheel: segment k/256, position k%256; scale with integer arithmetic.
  function automatic logic [23:0] model(input int k, input int b);
    int s, r;
    int c[3];
    s = (k / 256) % 6;
    r = k % 256;
    case (s)
      0: c = '{255, r, 0};
      1: c = '{255 - r, 255, 0};
      2: c = '{0, 255, r};
      3: c = '{0, 255 - r, 255};
      4: c = '{r, 0, 255};
      default: c = '{255, 0, 255 - r};
    endcase
    return {8'((c[0] * (b + 1)) / 256), 8'((c[1] * (b + 1)) / 256), 8'((c[2] * (b + 1)) / 256)};
  endfunction

  function automatic logic [2:0] model_seg(input int k);
    return 3'((k / 256) % 6);
  endfunction

  task automatic reset_dut(input logic [7:0] b, input logic rdy);
    rst = 1'b0;
    en = 1'b1;
    out_ready = rdy;
    bright = b;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    step = 0;
  endtask

  task automatic wait_load(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_load: out_valid never rose within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; out_ready = 1'b1; bright = 8'd255;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, duty_r, duty_g, duty_b, seg} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b duty=%h%h%h seg=%0d, want all zero", out_valid, duty_r, duty_g, duty_b, seg);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== 24'hFF0000 || seg !== 3'd0) begin
      n_bad++;
      $display("FAIL prime_load: got v=%b duty=%h%h%h seg=%0d, want v=1 duty=ff0000 seg=0", out_valid, duty_r, duty_g, duty_b, seg);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, duty_r, duty_g, duty_b, seg} !== 28'd0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b duty=%h%h%h seg=%0d, want all zero", out_valid, duty_r, duty_g, duty_b, seg);
    end
    @(negedge clk);
    reset_dut(8'd255, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_load(input string name, input int cyc, input int want_cyc, input int b);
    n_cmp++;
    if (cyc != want_cyc) begin
      n_bad++;
      $display("FAIL %s_interval: step %0d came after %0d cycles, want %0d", name, step, cyc, want_cyc);
    end
    n_cmp++;
    if ({duty_r, duty_g, duty_b} !== model(step, b) || seg !== model_seg(step)) begin
      n_bad++;
      $display("FAIL %s_triple: step %0d got %h%h%h seg=%0d, want %h seg=%0d", name, step, duty_r, duty_g, duty_b, seg, model(step, b), model_seg(step));
    end
  endtask

  task automatic test_stepping;
    int cyc;
    for (int i = 1; i <= 257; i++) begin
      wait_load(cyc);
      step++;
      check_load("stepping", cyc, 4, 255);
      if (step == 256) begin
        n_cmp++;
        if (seg !== 3'd1 || {duty_r, duty_g, duty_b} !== 24'hFFFF00) begin
          n_bad++;
          $display("FAIL seg1_entry: got seg=%0d duty=%h%h%h, want seg=1 duty=ffff00", seg, duty_r, duty_g, duty_b);
        end
      end
      if (step == 257) begin
        n_cmp++;
        if ({duty_r, duty_g, duty_b} !== 24'hFEFF00) begin
          n_bad++;
          $display("FAIL seg1_first_down: got %h%h%h, want feff00", duty_r, duty_g, duty_b);
        end
      end
    end
  endtask

  task automatic test_wheel_wrap;
    int cyc;
    while (step < 1536) begin
      wait_load(cyc);
      step++;
      check_load("wheel", cyc, 4, 255);
    end
    n_cmp++;
    if (seg !== 3'd0 || {duty_r, duty_g, duty_b} !== 24'hFF0000) begin
      n_bad++;
      $display("FAIL wheel_wrap: got seg=%0d duty=%h%h%h, want seg=0 duty=ff0000", seg, duty_r, duty_g, duty_b);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [23:0] held;
    logic [2:0]  hseg;
    for (int i = 0; i < 10; i++) begin
      wait_load(cyc);
      step++;
    end
    out_ready = 1'b0;
    held = {duty_r, duty_g, duty_b};
    hseg = seg;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== held || seg !== hseg) begin
        n_bad++;
        $display("FAIL stall_hold: cycle %0d got v=%b duty=%h%h%h seg=%0d, want v=1 duty=%h seg=%0d", i, out_valid, duty_r, duty_g, duty_b, seg, held, hseg);
      end
    end
    out_ready = 1'b1;
    wait_load(cyc);
    step++;
    check_load("after_stall", cyc, 4, 255);
  endtask

  task automatic test_pause;
    int cyc;
    logic [2:0] hseg;
    @(negedge clk);
    en = 1'b0;
    hseg = seg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || seg !== hseg) begin
        n_bad++;
        $display("FAIL pause_hold: cycle %0d got v=%b seg=%0d, want v=0 seg=%0d", i, out_valid, seg, hseg);
      end
    end
    en = 1'b1;
    wait_load(cyc);
    step++;
    check_load("resume", cyc, 3, 255);
  endtask

  task automatic test_scaling;
    reset_dut(8'd127, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== 24'h7F0000) begin
      n_bad++;
      $display("FAIL scale_127: got v=%b duty=%h%h%h, want v=1 duty=7f0000", out_valid, duty_r, duty_g, duty_b);
    end
    reset_dut(8'd0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== 24'h000000) begin
      n_bad++;
      $display("FAIL scale_0: got v=%b duty=%h%h%h, want v=1 duty=000000", out_valid, duty_r, duty_g, duty_b);
    end
    reset_dut(8'd255, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== 24'hFF0000) begin
      n_bad++;
      $display("FAIL scale_255: got v=%b duty=%h%h%h, want v=1 duty=ff0000", out_valid, duty_r, duty_g, duty_b);
    end
    bright = 8'd0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== 24'hFF0000) begin
      n_bad++;
      $display("FAIL scale_stall_bright: got v=%b duty=%h%h%h, want v=1 duty=ff0000", out_valid, duty_r, duty_g, duty_b);
    end
    out_ready = 1'b1;
    bright = 8'd255;
  endtask

  task automatic test_random;
    logic        prev_valid, prev_ready;
    logic [7:0]  b_cur;
    logic [23:0] held;
    reset_dut(8'($urandom), 1'b1);
    b_cur = bright;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    held = '0;
    step = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (prev_valid && !prev_ready) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {duty_r, duty_g, duty_b} !== held) begin
          n_bad++;
          $display("FAIL random_stall: cycle %0d got v=%b duty=%h%h%h, want v=1 duty=%h", i, out_valid, duty_r, duty_g, duty_b, held);
        end
      end else if (out_valid) begin
        step++;
        held = {duty_r, duty_g, duty_b};
        n_cmp++;
        if (held !== model(step, int'(b_cur)) || seg !== model_seg(step)) begin
          n_bad++;
          $display("FAIL random_triple: step %0d bright %0d got %h seg=%0d, want %h seg=%0d", step, b_cur, held, seg, model(step, int'(b_cur)), model_seg(step));
        end
      end
      prev_valid = out_valid;
      en         = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      bright     = 8'($urandom);
      b_cur      = bright;
      prev_ready = out_ready;
    end
    n_cmp++;
    if (step < 50) begin
      n_bad++;
      $display("FAIL random_progress: only %0d steps delivered, want at least 50", step);
    end
    en = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; out_ready = 1'b1; bright = 8'd255;
    test_reset;
    test_stepping;
    test_wheel_wrap;
    test_backpressure;
    test_pause;
    test_scaling;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
Generates a continuously cycling hue-wheel colour as three R-bit duty values (red, green, blue). Each value is scaled by a global brightness input. The block sits directly upstream of the per-channel PWM stages and delivers each new colour triple over a valid/ready handshake. It replaces free-running per-channel gradient generation with one phase-coherent colour source.

Parameters:
R, 8, duty resolution in bits; MAX = 2^R-1
STEP_THRESH, 100, clk cycles per ramp step (prescaler period), legal range >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  1 = prescaler runs; 0 = sequencer paused, state held
bright  in  R  global brightness, sampled when the output register loads
out_ready  in  1  downstream PWM accepts the current triple
out_valid  out  1  duty_r/g/b hold a new, unaccepted triple
duty_r  out  R  scaled red duty
duty_g  out  R  scaled green duty
duty_b  out  R  scaled blue duty
seg  out  3  current hue segment 0..5 (debug)

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - State: seg=0, ramp=0, prescaler=0, prime=1.
  - Outputs: out_valid=0, duty_r=duty_g=duty_b=0.
- stall = out_valid & ~out_ready.
- Prescaler:
  - Counts 0..STEP_THRESH-1 only when en & ~stall.
  - tick is asserted on the cycle the count equals STEP_THRESH-1; the count then wraps to 0.
  - STEP_THRESH=1 gives a tick on every enabled, non-stalled cycle.
- Step on tick:
  - If ramp < MAX: ramp increments by 1.
  - If ramp = MAX: ramp goes to 0 and seg advances; seg 5 wraps to 0.
- Raw levels, with up = ramp and dn = MAX-ramp:
  - seg0: (MAX, up, 0)
  - seg1: (dn, MAX, 0)
  - seg2: (0, MAX, up)
  - seg3: (0, dn, MAX)
  - seg4: (up, 0, MAX)
  - seg5: (MAX, 0, dn)
  - Segment boundaries repeat one triple. For example, seg0 ramp MAX and seg1 ramp 0 both give (MAX, MAX, 0). This is accepted.
- Scaling:
  - duty = (raw * (bright+1)) >> R, computed at full 2R+1 bit width, then truncated to R bits.
  - bright=MAX passes raw through unchanged; bright=0 forces 0.
- Output register load:
  - Loads on the clock edge after a step has updated seg/ramp, or on the first clock after reset release (prime, which then clears).
  - Load sets out_valid=1 and latches the scaled triple, using bright as sampled at that edge.
  - Latency: tick edge → state update; next edge → output load.
- Handshake:
  - A transfer occurs on a cycle where out_valid & out_ready.
  - After a transfer, out_valid clears unless a load occurs on the same edge; a load takes priority and out_valid stays 1.
  - While stall is true, duty_* and out_valid are held stable and the prescaler is frozen, so no step is ever dropped or overwritten.
  - Changing bright during a stall does not alter the held triple.
- Pause (en=0):
  - Prescaler, ramp and seg hold.
  - A pending triple still completes its handshake.
  - No new loads occur except the post-reset prime.
- Full wheel = 6*2^R steps = 6*2^R*STEP_THRESH unstalled cycles. After the full wheel, the sequence repeats exactly.

Test Plan:
1. Reset release. Setup: R=8, STEP_THRESH=4, bright=255, out_ready=1, en=1. Response: 1 clk after rst rises, out_valid=1 and duty=(255,0,0), seg=0. Asserting rst=0 mid-cycle zeroes all outputs before the next edge.
2. Stepping. Setup: as test 1, out_ready=1. Response: a new valid triple every 4 cycles, with duty_g counting 1,2,3,... After 256 steps seg=1 and duty=(255,255,0). The next triple is (254,255,0).
3. Wheel wrap. Setup: run 1536 steps. Response: seg returns to 0 and duty=(255,0,0). The checker's reference model agrees with every triple across all 6 segments.
4. Backpressure. Setup: drop out_ready for 20 cycles mid-segment. Response: out_valid stays 1, duty_* and seg are frozen and the prescaler holds. After out_ready returns, the next triple is exactly one step later, with no skip.
5. Scaling. Setup: seg0 ramp0. Response: bright=127 gives duty_r=127; bright=0 gives all zero; bright=255 gives 255. A bright change during a stall leaves the held value unchanged.
6. Pause. Setup: en=0 for 50 cycles with out_ready=1. Response: no out_valid pulses and seg/ramp are unchanged. With en=1 restored, the prescaler resumes from its held count.
